// File: rtl/mod47_stream_reducer.sv
// Horner-rule mod-47 reducer for an MSB-first stream of 6-bit digits.
// Each accepted digit applies r <- (17*r + d) mod 47 and the residue is handed off with a valid/ready handshake.
module mod47_stream_reducer #(
  parameter int unsigned MAXDIG = 8,
  localparam int unsigned W = $clog2(MAXDIG + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [5:0]   in_digit,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [5:0]   out_residue,
  output logic         out_ovf,
  output logic [W-1:0] digit_cnt
);

  typedef enum logic {ACC, DONE} state_t;

  state_t       state, state_n;
  logic [5:0]   acc, acc_n;
  logic [W-1:0] cnt, cnt_n;
  logic         ovf, ovf_n;

  logic [9:0]   x0;
  logic [8:0]   x1;
  logic [7:0]   x2;
  logic [5:0]   red;

  // Fold the 10-bit Horner term twice using 64 == 17 (mod 47); the result is
  // then at most 131, so two conditional subtractions finish the reduction.
  always_comb begin
    x0 = ({4'b0, acc} * 10'd17) + {4'b0, in_digit};
    x1 = ({5'b0, x0[9:6]} * 9'd17) + {3'b0, x0[5:0]};
    x2 = ({5'b0, x1[8:6]} * 8'd17) + {2'b0, x1[5:0]};
    if (x2 >= 8'd94)
      red = 6'(x2 - 8'd94);
    else if (x2 >= 8'd47)
      red = 6'(x2 - 8'd47);
    else
      red = x2[5:0];
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    ovf_n   = ovf;
    if (clr) begin
      state_n = ACC;
      acc_n   = '0;
      cnt_n   = '0;
      ovf_n   = 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (in_valid) begin
            acc_n = red;
            cnt_n = cnt + W'(1);
            if (in_last || (cnt_n == W'(MAXDIG))) begin
              state_n = DONE;
              ovf_n   = ~in_last;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_n = ACC;
            acc_n   = '0;
            cnt_n   = '0;
            ovf_n   = 1'b0;
          end
        end
        default: state_n = ACC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      ovf   <= ovf_n;
    end
  end

  assign in_ready    = (state == ACC);
  assign out_valid   = (state == DONE);
  assign out_residue = acc;
  assign out_ovf     = ovf;
  assign digit_cnt   = cnt;

endmodule

// File: tb/tb_mod47_stream_reducer.sv
// Bench for mod47_stream_reducer with MAXDIG=4: expected residues come from an
// integer value model (value mod 47) queued as operands are driven.
module tb_mod47_stream_reducer;
  localparam int unsigned MAXDIG = 4;
  localparam int unsigned W = $clog2(MAXDIG + 1);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         out_ready = 1'b0;
  logic [5:0]   in_digit = '0;
  logic         in_ready, out_valid, out_ovf;
  logic [5:0]   out_residue;
  logic [W-1:0] digit_cnt;

  typedef struct packed {
    logic [5:0]   res;
    logic         ovf;
    logic [W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  mod47_stream_reducer #(.MAXDIG(MAXDIG)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_digit(in_digit), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_residue(out_residue),
    .out_ovf(out_ovf), .digit_cnt(digit_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive n digits (packed MSB-first in digs) one per cycle; queue the expectation
  // when the operand is complete (last marked or MAXDIG reached).
  task automatic send(input int n, input logic [23:0] digs, input bit mark_last);
    longint v;
    logic [5:0] d;
    exp_t e;
    v = 0;
    for (int i = 0; i < n; i++) begin
      d = digs[23-6*i -: 6];
      in_valid = 1'b1;
      in_digit = d;
      in_last  = mark_last && (i == n - 1);
      v = v * 64 + longint'(d);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (mark_last || n == int'(MAXDIG)) begin
      e.res = 6'(v % 47);
      e.ovf = !mark_last;
      e.cnt = W'(n);
      sb.push_back(e);
    end
  endtask

  task automatic collect(input string name);
    exp_t e;
    int waited;
    waited = 0;
    while (out_valid !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL %s_wait out_valid=%b queued=%0d required out_valid=1 with queued result", name, out_valid, sb.size());
      if (sb.size() != 0) void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    checks++;
    if (out_residue !== e.res) begin
      errors++;
      $display("FAIL %s_residue got %0d expected %0d", name, out_residue, e.res);
    end
    checks++;
    if (out_ovf !== e.ovf) begin
      errors++;
      $display("FAIL %s_ovf got %b expected %b", name, out_ovf, e.ovf);
    end
    checks++;
    if (digit_cnt !== e.cnt) begin
      errors++;
      $display("FAIL %s_cnt got %0d expected %0d", name, digit_cnt, e.cnt);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || digit_cnt !== '0) begin
      errors++;
      $display("FAIL %s_release out_valid=%b in_ready=%b cnt=%0d expected 0 1 0", name, out_valid, in_ready, digit_cnt);
    end
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if ({in_ready, out_valid, out_residue, out_ovf, digit_cnt} !== {1'b1, 1'b0, 6'd0, 1'b0, W'(0)}) begin
      errors++;
      $display("FAIL %s rdy=%b vld=%b res=%0d ovf=%b cnt=%0d expected 1 0 0 0 0",
               name, in_ready, out_valid, out_residue, out_ovf, digit_cnt);
    end
  endtask

  task automatic test_reset();
    #12;
    check_reset_vals("reset_values");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    logic [23:0] tbl_d[5];
    int          tbl_n[5];
    tbl_d[0] = {6'd0, 6'd0, 6'd0, 6'd46};   tbl_n[0] = 4;
    tbl_d[1] = {6'd63, 6'd63, 6'd63, 6'd63}; tbl_n[1] = 4;
    tbl_d[2] = {6'd0, 6'd1, 6'd0, 6'd0};    tbl_n[2] = 4;
    tbl_d[3] = {6'd0, 6'd0, 6'd1, 6'd0};    tbl_n[3] = 4;
    tbl_d[4] = {6'd47, 18'd0};              tbl_n[4] = 1;
    for (int i = 0; i < 5; i++) begin
      send(tbl_n[i], tbl_d[i], 1'b1);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d_latency out_valid=%b in_ready=%b expected 1 0", i, out_valid, in_ready);
      end
      collect($sformatf("vec%0d", i));
    end
  endtask

  task automatic test_overflow();
    send(4, {6'd1, 6'd0, 6'd0, 6'd0}, 1'b0);
    in_valid = 1'b1;
    in_digit = 6'd5;
    in_last  = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovf_done in_ready=%b out_valid=%b expected 0 1", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (digit_cnt !== W'(4) || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ovf_hold cnt=%0d in_ready=%b expected 4 0", digit_cnt, in_ready);
    end
    collect("ovf");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    send(2, {6'd10, 6'd20, 12'd0}, 1'b1);
    e = sb[0];
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, out_residue, out_ovf, digit_cnt} !== {1'b1, 1'b0, e.res, e.ovf, e.cnt}) begin
        errors++;
        $display("FAIL bp_stable%0d vld=%b rdy=%b res=%0d ovf=%b cnt=%0d expected 1 0 %0d %b %0d",
                 c, out_valid, in_ready, out_residue, out_ovf, digit_cnt, e.res, e.ovf, e.cnt);
      end
    end
    void'(sb.pop_front());
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_digit  = 6'd33;
    in_last   = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (digit_cnt !== '0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release cnt=%0d rdy=%b vld=%b expected 0 1 0", digit_cnt, in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    e.res = 6'(33 % 47);
    e.ovf = 1'b0;
    e.cnt = W'(1);
    sb.push_back(e);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_next_accept out_valid=%b expected 1", out_valid);
    end
    collect("bp_next");
  endtask

  task automatic test_clr();
    send(2, {6'd5, 6'd9, 12'd0}, 1'b0);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_digit = 6'd7;
    in_last  = 1'b1;
    @(posedge clk); #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++;
    if (digit_cnt !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL clr_mid cnt=%0d vld=%b rdy=%b expected 0 0 1", digit_cnt, out_valid, in_ready);
    end
    send(1, {6'd2, 18'd0}, 1'b1);
    collect("clr_after");
    send(1, {6'd50, 18'd0}, 1'b1);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    void'(sb.pop_front());
    checks++;
    if (out_valid !== 1'b0 || digit_cnt !== '0 || out_residue !== 6'd0) begin
      errors++;
      $display("FAIL clr_done vld=%b cnt=%0d res=%0d expected 0 0 0", out_valid, digit_cnt, out_residue);
    end
  endtask

  task automatic test_async_reset();
    send(2, {6'd12, 6'd34, 12'd0}, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_soak();
    int n;
    bit ml;
    for (int k = 0; k < 10000; k++) begin
      n  = $urandom_range(1, MAXDIG);
      ml = (n < int'(MAXDIG)) ? 1'b1 : 1'($urandom_range(0, 1));
      send(n, 24'($urandom), ml);
      collect("soak");
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_overflow();
    test_back_to_back();
    test_clr();
    test_async_reset();
    test_soak();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty got %0d entries expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
